// File: rtl/pwm_demodulator_if.sv
// Bus between a PWM stream source/consumer (master) and the demodulator (slave).
interface pwm_demodulator_if #(
  parameter int DUTY_WIDTH = 7
);
  logic                  pwm_in;
  logic                  enable;
  logic [DUTY_WIDTH-1:0] duty;
  logic                  duty_valid;
  logic                  locked;
  logic                  sync_err;

  modport master (
    output pwm_in,
    output enable,
    input  duty,
    input  duty_valid,
    input  locked,
    input  sync_err
  );

  modport slave (
    input  pwm_in,
    input  enable,
    output duty,
    output duty_valid,
    output locked,
    output sync_err
  );
endinterface

// File: rtl/pwm_demodulator.sv
// Recovers one high-step count per PWM symbol from a serial high-first PWM
// stream, aligning on rising edges and tracking lock across clean symbols.
module pwm_demodulator #(
  parameter int CLKS_PER_STEP = 2,
  parameter int PWM_STEPS     = 64,
  parameter int LOCK_SYMBOLS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  pwm_demodulator_if.slave bus
);

  localparam int DUTY_WIDTH = $clog2(PWM_STEPS + 1);
  localparam int CW         = (CLKS_PER_STEP > 1) ? $clog2(CLKS_PER_STEP) : 1;
  localparam int SW         = $clog2(PWM_STEPS);
  localparam int GW         = $clog2(LOCK_SYMBOLS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HUNT  = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [CW-1:0]         CLK_ZERO   = CW'(1'b0);
  localparam logic [CW-1:0]         CLK_ONE    = CW'(1'b1);
  localparam logic [CW-1:0]         CLK_LAST   = CW'(CLKS_PER_STEP - 1);
  localparam logic [CW-1:0]         SAMPLE_PT  = CW'(CLKS_PER_STEP / 2);
  localparam logic [SW-1:0]         STEP_ZERO  = SW'(1'b0);
  localparam logic [SW-1:0]         STEP_ONE   = SW'(1'b1);
  localparam logic [SW-1:0]         STEP_LAST  = SW'(PWM_STEPS - 1);
  localparam logic [DUTY_WIDTH-1:0] ACC_ZERO   = DUTY_WIDTH'(1'b0);
  localparam logic [DUTY_WIDTH-1:0] ACC_ONE    = DUTY_WIDTH'(1'b1);
  localparam logic [GW-1:0]         GOOD_ZERO  = GW'(1'b0);
  localparam logic [GW-1:0]         GOOD_ONE   = GW'(1'b1);
  localparam logic [GW-1:0]         LOCK_CNT   = GW'(LOCK_SYMBOLS);

  logic                  sync1_q, pwm_s_q, pwm_d_q;
  logic [1:0]            state_q, state_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [SW-1:0]         step_cnt_q, step_cnt_d;
  logic [DUTY_WIDTH-1:0] acc_q, acc_d;
  logic [GW-1:0]         good_q, good_d;
  logic [DUTY_WIDTH-1:0] duty_q, duty_d;
  logic                  duty_valid_q, duty_valid_d;
  logic                  locked_q, locked_d;
  logic                  sync_err_q, sync_err_d;

  logic                  rise_s, at_origin_s, process_s, restart_s;
  logic [CW-1:0]         clk_pos_s;
  logic [SW-1:0]         step_pos_s;
  logic [DUTY_WIDTH-1:0] acc_sum_s;
  logic [GW-1:0]         good_inc_s;

  // Next-state: alignment, sampling, symbol completion and lock bookkeeping.
  always_comb begin
    rise_s       = pwm_s_q & ~pwm_d_q;
    at_origin_s  = (clk_cnt_q == CLK_ZERO) && (step_cnt_q == STEP_ZERO);
    good_inc_s   = (good_q == LOCK_CNT) ? good_q : good_q + GOOD_ONE;
    process_s    = 1'b0;
    restart_s    = 1'b0;
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    step_cnt_d   = step_cnt_q;
    acc_d        = acc_q;
    good_d       = good_q;
    duty_d       = duty_q;
    duty_valid_d = 1'b0;
    locked_d     = locked_q;
    sync_err_d   = 1'b0;
    clk_pos_s    = clk_cnt_q;
    step_pos_s   = step_cnt_q;
    acc_sum_s    = acc_q;

    if (!bus.enable) begin
      state_d    = ST_IDLE;
      clk_cnt_d  = CLK_ZERO;
      step_cnt_d = STEP_ZERO;
      acc_d      = ACC_ZERO;
      good_d     = GOOD_ZERO;
      locked_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          clk_cnt_d  = CLK_ZERO;
          step_cnt_d = STEP_ZERO;
          acc_d      = ACC_ZERO;
          good_d     = GOOD_ZERO;
          locked_d   = 1'b0;
          state_d    = ST_HUNT;
        end
        ST_HUNT: begin
          if (rise_s) begin
            state_d   = ST_TRACK;
            process_s = 1'b1;
          end else begin
            state_d   = ST_HUNT;
          end
        end
        ST_TRACK: begin
          process_s = 1'b1;
          // An edge off the symbol origin re-anchors the frame at this cycle.
          if (rise_s && !at_origin_s) begin
            restart_s  = 1'b1;
            sync_err_d = 1'b1;
            good_d     = GOOD_ZERO;
            locked_d   = 1'b0;
          end else begin
            restart_s  = 1'b0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          clk_cnt_d  = CLK_ZERO;
          step_cnt_d = STEP_ZERO;
          acc_d      = ACC_ZERO;
          good_d     = GOOD_ZERO;
          locked_d   = 1'b0;
        end
      endcase

      clk_pos_s  = restart_s ? CLK_ZERO : clk_cnt_q;
      step_pos_s = restart_s ? STEP_ZERO : step_cnt_q;
      acc_sum_s  = (restart_s ? ACC_ZERO : acc_q) +
                   (((clk_pos_s == SAMPLE_PT) && pwm_s_q) ? ACC_ONE : ACC_ZERO);

      if (process_s) begin
        if (clk_pos_s == CLK_LAST) begin
          clk_cnt_d = CLK_ZERO;
          if (step_pos_s == STEP_LAST) begin
            step_cnt_d   = STEP_ZERO;
            acc_d        = ACC_ZERO;
            duty_d       = acc_sum_s;
            duty_valid_d = 1'b1;
            good_d       = good_inc_s;
            locked_d     = (good_inc_s == LOCK_CNT);
          end else begin
            step_cnt_d   = step_pos_s + STEP_ONE;
            acc_d        = acc_sum_s;
          end
        end else begin
          clk_cnt_d  = clk_pos_s + CLK_ONE;
          step_cnt_d = step_pos_s;
          acc_d      = acc_sum_s;
        end
      end else begin
        clk_cnt_d  = clk_cnt_q;
      end
    end
  end

  // Input synchronizer; resets to 1 so a line already high is not taken as an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      pwm_s_q <= 1'b1;
      pwm_d_q <= 1'b1;
    end else begin
      sync1_q <= bus.pwm_in;
      pwm_s_q <= sync1_q;
      pwm_d_q <= pwm_s_q;
    end
  end

  // Tracking state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      clk_cnt_q    <= CLK_ZERO;
      step_cnt_q   <= STEP_ZERO;
      acc_q        <= ACC_ZERO;
      good_q       <= GOOD_ZERO;
      duty_q       <= ACC_ZERO;
      duty_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      step_cnt_q   <= step_cnt_d;
      acc_q        <= acc_d;
      good_q       <= good_d;
      duty_q       <= duty_d;
      duty_valid_q <= duty_valid_d;
      locked_q     <= locked_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = duty_valid_q;
  assign bus.locked     = locked_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_pwm_demodulator.sv
// Directed bench for pwm_demodulator: a symbol-level model checked every cycle
// plus literal expectations on the recovered duty sequence and lock/error counts.
module tb_pwm_demodulator;
  localparam int CPS   = 2;
  localparam int STEPS = 64;
  localparam int LOCK  = 4;
  localparam int SYM   = CPS * STEPS;
  localparam int DW    = 7;

  logic clk = 1'b0;
  logic rst;

  pwm_demodulator_if #(.DUTY_WIDTH(DW)) bus ();

  pwm_demodulator #(
    .CLKS_PER_STEP(CPS),
    .PWM_STEPS    (STEPS),
    .LOCK_SYMBOLS (LOCK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Symbol-level model: position is (cycle - symbol start) mod symbol length.
  int     m_mode;          // 0 idle, 1 hunt, 2 track
  longint m_cyc, m_start;
  int     m_ones, m_good, m_duty, m_pos;
  logic   m_s1, m_s2, m_d, m_rise, m_run;
  logic   m_dv, m_locked, m_se;
  logic   model_valid = 1'b0;

  int   dv_q[$];
  int   lock_rises = 0;
  int   first_lock_dv = -1;
  int   se_count = 0;
  logic prev_locked = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_mode = 0; m_cyc = 0; m_start = 0; m_ones = 0; m_good = 0;
        m_s1 = 1'b1; m_s2 = 1'b1; m_d = 1'b1;
        m_duty = 0; m_dv = 1'b0; m_locked = 1'b0; m_se = 1'b0;
        model_valid = 1'b1;
      end else begin
        m_rise = m_s2 && !m_d;
        m_dv = 1'b0; m_se = 1'b0; m_run = 1'b0;
        if (!bus.enable) begin
          m_mode = 0; m_good = 0; m_locked = 1'b0; m_ones = 0;
        end else if (m_mode == 0) begin
          m_mode = 1;
        end else if (m_mode == 1) begin
          if (m_rise) begin
            m_mode = 2; m_start = m_cyc; m_ones = 0; m_run = 1'b1;
          end
        end else begin
          m_run = 1'b1;
          if (m_rise && ((m_cyc - m_start) % SYM) != 0) begin
            m_se = 1'b1; m_good = 0; m_locked = 1'b0; m_start = m_cyc; m_ones = 0;
          end
        end
        if (m_run) begin
          m_pos = int'((m_cyc - m_start) % SYM);
          if ((m_pos % CPS) == (CPS / 2) && m_s2) m_ones++;
          if (m_pos == SYM - 1) begin
            m_dv = 1'b1; m_duty = m_ones; m_ones = 0;
            if (m_good < LOCK) m_good++;
            if (m_good >= LOCK) m_locked = 1'b1;
          end
        end
        m_d = m_s2; m_s2 = m_s1; m_s1 = bus.pwm_in;
        m_cyc++;
      end
    end
  end

  // Every-cycle comparison against the model, plus event logging.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        n_vec++;
        if (bus.duty !== DW'(m_duty) || bus.duty_valid !== m_dv ||
            bus.locked !== m_locked || bus.sync_err !== m_se) begin
          n_err++;
          $display("FAIL cycle t=%0t: duty %0d want %0d, dv %b want %b, locked %b want %b, sync_err %b want %b",
                   $time, bus.duty, m_duty, bus.duty_valid, m_dv, bus.locked, m_locked, bus.sync_err, m_se);
        end
        if (bus.duty_valid === 1'b1) dv_q.push_back(int'(bus.duty));
        if (bus.locked === 1'b1 && !prev_locked) begin
          lock_rises++;
          if (lock_rises == 1) first_lock_dv = dv_q.size();
        end
        prev_locked = (bus.locked === 1'b1);
        if (bus.sync_err === 1'b1) se_count++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic send_raw(input int n, input logic v);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.pwm_in = v;
    end
  endtask

  task automatic send_sym(input int d, input int drop_at, input int rst_at);
    for (int i = 0; i < SYM; i++) begin
      @(negedge clk);
      if (drop_at >= 0 && i == drop_at) check("pre_drop_locked", int'(bus.locked), 1);
      if (drop_at >= 0 && i == drop_at + 1) begin
        check("drop_locked", int'(bus.locked), 0);
        check("drop_dv", int'(bus.duty_valid), 0);
        check("drop_duty_hold", int'(bus.duty), 32);
      end
      if (rst_at >= 0 && i == rst_at + 1) begin
        check("midrst_duty", int'(bus.duty), 0);
        check("midrst_dv", int'(bus.duty_valid), 0);
        check("midrst_locked", int'(bus.locked), 0);
        check("midrst_sync_err", int'(bus.sync_err), 0);
      end
      bus.pwm_in = ((i / CPS) < d);
      bus.enable = (i != drop_at);
      rst        = (i == rst_at);
    end
  endtask

  int exp_list[$] = '{32, 32, 32, 32, 32, 33, 35, 37, 63, 0, 64, 0, 32, 32,
                      32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32, 32};
  int dv_before, se_before;

  initial begin
    rst = 1'b1; bus.enable = 1'b1; bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_duty", int'(bus.duty), 0);
    check("reset_dv", int'(bus.duty_valid), 0);
    check("reset_locked", int'(bus.locked), 0);
    check("reset_sync_err", int'(bus.sync_err), 0);
    rst = 1'b0;
    send_raw(4, 1'b0);

    repeat (5) send_sym(32, -1, -1);
    send_sym(33, -1, -1); send_sym(35, -1, -1); send_sym(37, -1, -1); send_sym(63, -1, -1);
    send_sym(0, -1, -1); send_sym(64, -1, -1); send_sym(0, -1, -1);
    repeat (2) send_sym(32, -1, -1);
    // Broken symbol: low-high glitch puts a rising edge at step 40, clock 1.
    send_raw(64, 1'b1); send_raw(17, 1'b0);
    repeat (5) send_sym(32, -1, -1);
    send_sym(32, 40, -1);
    repeat (5) send_sym(32, -1, -1);
    send_sym(32, -1, 50);
    repeat (2) send_sym(32, -1, -1);
    send_raw(8, 1'b0);

    check("first_lock_at_dv", first_lock_dv, 4);
    check("lock_rises", lock_rises, 3);
    check("sync_err_pulses", se_count, 1);
    check("dv_count", dv_q.size(), exp_list.size());
    for (int k = 0; k < exp_list.size() && k < dv_q.size(); k++)
      check($sformatf("dv_value[%0d]", k), dv_q[k], exp_list[k]);

    // Constant line from reset: must stay hunting with quiet outputs.
    @(negedge clk); rst = 1'b1; bus.pwm_in = 1'b1;
    @(negedge clk); rst = 1'b0;
    dv_before = dv_q.size(); se_before = se_count;
    send_raw(1000, 1'b1);
    check("hold_high_dv", dv_q.size() - dv_before, 0);
    check("hold_high_locked", int'(bus.locked), 0);
    send_raw(1000, 1'b0);
    check("hold_low_dv", dv_q.size() - dv_before, 0);
    check("hold_low_sync_err", se_count - se_before, 0);
    check("hold_low_locked", int'(bus.locked), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/pwm_demodulator.md
Name: pwm_demodulator

Overview:
- Receive-side counterpart of the AM PWM modulator: recovers one duty-cycle sample per PWM symbol from a serial PWM bitstream.
- Each symbol is PWM_STEPS steps of CLKS_PER_STEP clocks; high steps come first (MSB-first serialization), then low.
- Aligns to the symbol's rising edge, samples mid-step, counts high steps and emits the count with a one-cycle valid strobe.
- Used in loopback self-test of the transmit chain and as the front end of the receive path.

Parameters:
- CLKS_PER_STEP, 2, clocks per PWM step; must be >= 1.
- PWM_STEPS, 64, steps per PWM symbol; must be >= 2.
- LOCK_SYMBOLS, 4, consecutive error-free complete symbols required before locked asserts.
- DUTY_WIDTH (localparam), $clog2(PWM_STEPS+1), width of the duty output; 7 at the defaults, covering 0..64.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- pwm_in  input  1  serial PWM stream; may be asynchronous to clk
- enable  input  1  1 = demodulate; 0 = idle, clear tracking
- duty  output  DUTY_WIDTH  high-step count of the last completed symbol, held between updates
- duty_valid  output  1  one-cycle strobe: duty updated this cycle
- locked  output  1  high after LOCK_SYMBOLS consecutive clean symbols
- sync_err  output  1  one-cycle pulse: rising edge at an unexpected symbol position

Behaviour:
- Reset and reset mid-operation. Every output and internal register returns to its reset value on the next edge: duty=0, duty_valid=0, locked=0, sync_err=0, state=IDLE, all counters 0. Any partial symbol is discarded.
- Input conditioning. pwm_in passes through a 2-FF synchronizer to give pwm_s, plus one delay register pwm_d. A rising edge is the cycle where pwm_s=1 and pwm_d=0. Latency from pwm_in to pwm_s is 2 clocks, fixed.
- Position counters. clk_cnt runs 0..CLKS_PER_STEP-1; step_cnt runs 0..PWM_STEPS-1.
- Sampling. The sample point is clk_cnt == CLKS_PER_STEP/2 (integer division). At the sample point, acc += pwm_s.
- States:
  - IDLE: counters and acc held at 0; duty_valid=0; locked=0. Goes to HUNT when enable=1.
  - HUNT: waits for a rising edge. The edge cycle is position (step 0, clk 0) of a new symbol: it is sampled if it is the sample point, and the state goes to TRACK. pwm_in held high or held low stays in HUNT indefinitely with no outputs.
  - TRACK: counters freewheel, and the position wraps (PWM_STEPS-1, CLKS_PER_STEP-1) -> (0,0).
- Symbol completion, on the cycle at position (PWM_STEPS-1, CLKS_PER_STEP-1):
  - On the next clock edge, duty <= final acc (including the last step's sample) and duty_valid <= 1 for exactly one cycle.
  - acc clears for the next symbol; the good-symbol counter increments, saturating at LOCK_SYMBOLS.
  - locked <= 1 once the good-symbol counter reaches LOCK_SYMBOLS.
- Rising edge in TRACK:
  - At the expected position (0,0): normal operation, no action.
  - At any other position: sync_err pulses for 1 cycle; the partial symbol is dropped (no duty_valid); the good-symbol counter and locked clear; this cycle becomes (0,0) of a new symbol (acc restarts, including this cycle if it is a sample point). State stays TRACK.
- Duty 0 or duty PWM_STEPS symbols contain no rising edge. TRACK freewheels and reports 0 or PWM_STEPS respectively, without sync_err.
- Completion at the last position followed by an edge on the next cycle (0,0) is the normal case and produces no error.
- enable deasserted in any state:
  - Next cycle: state=IDLE, locked=0, acc and counters cleared, no duty_valid for the partial symbol.
  - duty holds its last value.
  - If enable falls on a completion cycle, that duty_valid is suppressed.
- duty_valid is emitted for every completed symbol whether or not locked=1; consumers qualify it with locked.
- Arithmetic: acc is DUTY_WIDTH bits and cannot overflow (at most PWM_STEPS samples per symbol).

Test Plan (defaults CLKS_PER_STEP=2, PWM_STEPS=64, LOCK_SYMBOLS=4; stimulus is an ideal modulator stream):
- Continuous duty 32 symbols -> duty_valid every 128 clocks with duty=32; locked rises on the 4th duty_valid; sync_err never asserts.
- Symbol sequence 33,35,37,63 after lock -> duty_valid values 33,35,37,63 in order; locked stays 1.
- After lock: one all-low symbol (duty 0), then one all-high symbol (duty 64) -> duty=0 then duty=64 (64 only if the following symbol starts low; otherwise its edge is absent); locked stays 1; no sync_err.
- Locked at duty 32; inject a 2-clock low-high glitch giving a rising edge at step 40 -> sync_err one-cycle pulse; locked=0 next cycle; no duty_valid for the broken symbol; next valid duty comes from the symbol starting at the glitch edge; locked returns after 4 further clean symbols.
- Locked, mid-symbol: drop enable for 1 cycle -> locked=0, no duty_valid, duty holds 32; re-enable -> HUNT, re-lock after edge + 4 symbols. Separately, pulse rst mid-symbol -> duty=0, duty_valid=0, locked=0, sync_err=0 next cycle.
- From reset with pwm_in held constant 1 (then constant 0) for 1000 clocks -> state stays HUNT; duty_valid, locked and sync_err all 0.
